// File: rtl/alu32_issuer.sv
// Request/response front-end for the registered 32-bit ALU: issues operands, waits out the
// ALU latency, then returns the captured result. Optional ALU_ISSUE_OPCHECK_EN rejects opcodes > MAX_OP.
module alu32_issuer #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_OP  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [3:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("alu32_issuer: LATENCY must be in 1..15");
  end
  if (MAX_OP > 15) begin : g_bad_max_op
    $error("alu32_issuer: MAX_OP must fit the 4-bit opcode");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu32_issuer: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [3:0] WaitLoad = 4'(LATENCY);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_op;

`ifdef ALU_ISSUE_OPCHECK_EN
  localparam logic [3:0] MaxOpSel = 4'(MAX_OP);

  logic rsp_err_q, rsp_err_d;

  assign illegal_op = (req_op > MaxOpSel);
  assign rsp_err    = rsp_err_q;
`else
  assign illegal_op = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rsp_data_d = rsp_data_q;
    count_d    = count_q;
`ifdef ALU_ISSUE_OPCHECK_EN
    rsp_err_d  = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (illegal_op) begin
            // Rejected opcodes never reach the ALU; answer immediately with an error.
            rsp_data_d = '0;
            state_d    = StResp;
`ifdef ALU_ISSUE_OPCHECK_EN
            rsp_err_d  = 1'b1;
`endif
          end else begin
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_sel_d = req_op;
            wait_d    = WaitLoad;
            state_d   = StWait;
`ifdef ALU_ISSUE_OPCHECK_EN
            rsp_err_d = 1'b0;
`endif
          end
        end
      end
      StWait: begin
        if (wait_q == 4'd0) begin
          rsp_data_d = alu_out;
          state_d    = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          if (!(&count_q)) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rsp_data_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rsp_data_q <= rsp_data_d;
      count_q    <= count_d;
    end
  end

`ifdef ALU_ISSUE_OPCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = count_q;

endmodule
